uart_packet_rx: RTL and testbench

- Receive side of the game's serial link: deserializes the RxD line into bytes, frames them into fixed-length game-state packets, and validates each packet with a checksum.
- Delivers a 176-bit packet word with the same bit layout the packet assembler produces.
- Sits between the board RxD pin and the game logic, or a display/host-loopback consumer.

---
 rtl/game_link_pkg.sv | 33 +++
 rtl/uart_byte_rx.sv | 94 +++++++++
 rtl/uart_packet_rx.sv | 102 ++++++++++
 tb/tb_uart_packet_rx.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_link_pkg.sv
// Constants, packet field map and FSM state types for the game serial link.
package game_link_pkg;

  localparam int unsigned PKT_BYTES = 22;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  // Field offsets (MSB index and width) inside the 176-bit packet word
  localparam int unsigned PLAYER_X_MSB      = 175;
  localparam int unsigned PLAYER_X_W        = 8;
  localparam int unsigned PLAYER_Y_MSB      = 167;
  localparam int unsigned PLAYER_Y_W        = 8;
  localparam int unsigned WAVE_Y_MSB        = 159;
  localparam int unsigned WAVE_Y_W          = 24;
  localparam int unsigned WAVE_BITFIELD_MSB = 135;
  localparam int unsigned WAVE_BITFIELD_W   = 120;
  localparam int unsigned HIGH_SCORE_MSB    = 15;
  localparam int unsigned HIGH_SCORE_W      = 16;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } pkt_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } byte_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, framing check.
module uart_byte_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);
  import game_link_pkg::*;

  localparam int unsigned    CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  byte_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;

  // shift only moves in DATA, so it is stable while byte_valid is high
  assign byte_data = shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rxd;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              state      <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_packet_rx.sv
// Packet framer: hunts for the sync byte, collects the payload into a shadow
// buffer, validates the XOR checksum and publishes whole packets atomically.
module uart_packet_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PKT_BYTES    = game_link_pkg::PKT_BYTES,
  parameter logic [7:0]  SYNC_BYTE    = game_link_pkg::SYNC_BYTE,
  parameter int unsigned TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rxd,
  output logic [PKT_BYTES*8-1:0] pkt_data,
  output logic                   pkt_valid,
  output logic                   frame_err,
  output logic                   chk_err,
  output logic                   rx_busy
);
  import game_link_pkg::*;

  localparam int unsigned PKT_W = PKT_BYTES * 8;
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned IDX_W = $clog2(PKT_BYTES);

  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             byte_frame_err;
  pkt_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       chk;
  logic [PKT_W-1:0] shadow;
  logic [GAP_W-1:0] gap;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (byte_frame_err)
  );

  assign frame_err = byte_frame_err;
  assign rx_busy   = (state != HUNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= HUNT;
      idx       <= '0;
      chk       <= '0;
      shadow    <= '0;
      gap       <= '0;
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      chk_err   <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      chk_err   <= 1'b0;
      if (state == HUNT || byte_valid) gap <= '0;
      else                             gap <= gap + GAP_W'(1);
      case (state)
        HUNT: begin
          if (byte_valid && byte_data == SYNC_BYTE) begin
            state <= PAYLOAD;
            idx   <= '0;
            chk   <= 8'h00;
          end
        end
        PAYLOAD, CHECK: begin
          if (byte_frame_err) begin
            state <= HUNT;
          end else if (byte_valid) begin
            if (state == PAYLOAD) begin
              // Shifting in from the LSB leaves byte 0 at the MSB after a full
              // payload, the same layout as indexed writes to shadow[idx].
              shadow <= {shadow[PKT_W-9:0], byte_data};
              chk    <= chk ^ byte_data;
              idx    <= idx + IDX_W'(1);
              if (idx == IDX_W'(PKT_BYTES - 1)) state <= CHECK;
            end else begin
              if (byte_data == chk) begin
                pkt_data  <= shadow;
                pkt_valid <= 1'b1;
              end else begin
                chk_err <= 1'b1;
              end
              state <= HUNT;
            end
          end else if (gap == GAP_W'(TIMEOUT_CLKS - 2)) begin
            // gap clears one clock after byte_valid; firing at TIMEOUT_CLKS-2
            // puts the chk_err pulse TIMEOUT_CLKS clocks after byte_valid.
            chk_err <= 1'b1;
            state   <= HUNT;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Scoreboard bench for uart_packet_rx with a short bit period.
module tb_uart_packet_rx;

  localparam int unsigned CPB     = 16;
  localparam int unsigned NBYTES  = 22;
  localparam int unsigned PKT_W   = NBYTES * 8;
  localparam int unsigned TIMEOUT = 20 * CPB;
  localparam logic [7:0]  SYNC    = 8'hA5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rxd = 1'b1;
  logic [PKT_W-1:0] pkt_data;
  logic             pkt_valid;
  logic             frame_err;
  logic             chk_err;
  logic             rx_busy;

  uart_packet_rx #(
    .CLKS_PER_BIT(CPB),
    .PKT_BYTES   (NBYTES),
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CLKS(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .pkt_data (pkt_data),
    .pkt_valid(pkt_valid),
    .frame_err(frame_err),
    .chk_err  (chk_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               n_pv = 0;
  int               n_chk = 0;
  int               n_fe = 0;
  int               n_bv = 0;
  int               last_bv = 0;
  int               last_chk = 0;
  logic             busy_at_chk = 1'b0;
  logic [PKT_W-1:0] exp_q[$];
  logic [PKT_W-1:0] last_good = '0;

  always @(posedge clk) cyc++;

  // Output monitor: pops the scoreboard on every published packet
  always @(negedge clk) begin
    if (rst_n) begin
      if (dut.u_byte_rx.byte_valid) begin
        n_bv++;
        last_bv = cyc;
      end
      if (chk_err) begin
        n_chk++;
        last_chk = cyc;
        busy_at_chk = rx_busy;
      end
      if (frame_err) n_fe++;
      if (pkt_valid) begin
        logic [PKT_W-1:0] e;
        n_pv++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pkt: got %0h expected no packet", pkt_data);
        end else begin
          e = exp_q.pop_front();
          if (pkt_data !== e) begin
            errors++;
            $display("FAIL pkt_data: got %0h expected %0h", pkt_data, e);
          end
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clks(CPB);
    end
    rxd = stop;
    wait_clks(CPB);
    rxd = 1'b1;
    wait_clks(2);
  endtask

  function automatic logic [7:0] xor_chk(input logic [PKT_W-1:0] p);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < int'(NBYTES); i++) c = c ^ p[PKT_W-1-8*i -: 8];
    return c;
  endfunction

  function automatic logic [PKT_W-1:0] seq_payload(input logic [7:0] first);
    logic [PKT_W-1:0] p;
    for (int i = 0; i < int'(NBYTES); i++) p[PKT_W-1-8*i -: 8] = first + 8'(i);
    return p;
  endfunction

  task automatic send_frame(input logic [PKT_W-1:0] p, input logic [7:0] c);
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < int'(NBYTES); i++) send_byte(p[PKT_W-1-8*i -: 8], 1'b1);
    send_byte(c, 1'b1);
  endtask

  task automatic send_good(input logic [PKT_W-1:0] p);
    exp_q.push_back(p);
    last_good = p;
    send_frame(p, xor_chk(p));
    wait_clks(40);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_clks(3);
    checks++;
    if ({pkt_valid, frame_err, chk_err, rx_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {pkt_valid, frame_err, chk_err, rx_busy});
    end
    checks++;
    if (pkt_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %0h expected 0", pkt_data);
    end
    rst_n = 1'b1;
    wait_clks(5);
  endtask

  task automatic test_good_packet;
    int pv0 = n_pv, ce0 = n_chk, fe0 = n_fe;
    logic [PKT_W-1:0] p = seq_payload(8'h01);
    checks++;
    if (xor_chk(p) !== 8'h17) begin
      errors++;
      $display("FAIL good_chk_value: got %0h expected 17", xor_chk(p));
    end
    send_good(p);
    checks++;
    if (n_pv - pv0 != 1 || n_chk != ce0 || n_fe != fe0) begin
      errors++;
      $display("FAIL good_counts: got pv=%0d ce=%0d fe=%0d expected 1 0 0", n_pv - pv0, n_chk - ce0, n_fe - fe0);
    end
    checks++;
    if (pkt_data[175:168] !== 8'h01 || pkt_data[7:0] !== 8'h16) begin
      errors++;
      $display("FAIL good_ends: got %0h/%0h expected 01/16", pkt_data[175:168], pkt_data[7:0]);
    end
  endtask

  task automatic test_bad_checksum;
    int pv0 = n_pv, ce0 = n_chk;
    send_frame(seq_payload(8'h01), 8'h00);
    wait_clks(40);
    checks++;
    if (n_chk - ce0 != 1 || n_pv != pv0) begin
      errors++;
      $display("FAIL bad_chk_counts: got ce=%0d pv=%0d expected 1 0", n_chk - ce0, n_pv - pv0);
    end
    checks++;
    if (pkt_data !== last_good) begin
      errors++;
      $display("FAIL bad_chk_hold: got %0h expected %0h", pkt_data, last_good);
    end
  endtask

  task automatic test_sync_hunt;
    int pv0 = n_pv, ce0 = n_chk;
    logic [PKT_W-1:0] p = seq_payload(8'h30);
    p[PKT_W-1-8*3 -: 8] = SYNC;
    send_byte(8'h00, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_good(p);
    checks++;
    if (n_pv - pv0 != 1 || n_chk != ce0) begin
      errors++;
      $display("FAIL sync_hunt: got pv=%0d ce=%0d expected 1 0", n_pv - pv0, n_chk - ce0);
    end
  endtask

  task automatic test_framing_error;
    int pv0 = n_pv, ce0 = n_chk, fe0 = n_fe;
    logic [PKT_W-1:0] p = seq_payload(8'h50);
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(p[PKT_W-1-8*i -: 8], 1'b1);
    send_byte(p[PKT_W-1-8*4 -: 8], 1'b0);
    wait_clks(40);
    checks++;
    if (n_fe - fe0 != 1 || n_chk != ce0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_err: got fe=%0d ce=%0d busy=%b expected 1 0 0", n_fe - fe0, n_chk - ce0, rx_busy);
    end
    send_good(seq_payload(8'h60));
    checks++;
    if (n_pv - pv0 != 1) begin
      errors++;
      $display("FAIL frame_err_recover: got pv=%0d expected 1", n_pv - pv0);
    end
  endtask

  task automatic test_glitch;
    int pv0 = n_pv, ce0 = n_chk, fe0 = n_fe, bv0 = n_bv;
    rxd = 1'b0;
    wait_clks(4);
    rxd = 1'b1;
    wait_clks(60);
    checks++;
    if (n_bv != bv0 || n_pv != pv0 || n_chk != ce0 || n_fe != fe0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch: got bv=%0d pv=%0d ce=%0d fe=%0d busy=%b expected all 0", n_bv - bv0, n_pv - pv0, n_chk - ce0, n_fe - fe0, rx_busy);
    end
  endtask

  task automatic test_timeout;
    int ce0 = n_chk;
    int waited = 0;
    logic [PKT_W-1:0] p = seq_payload(8'h70);
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < 10; i++) send_byte(p[PKT_W-1-8*i -: 8], 1'b1);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_busy: got %b expected 1", rx_busy);
    end
    while (n_chk == ce0 && waited < TIMEOUT + 200) begin
      wait_clks(1);
      waited++;
    end
    checks++;
    if (n_chk == ce0) begin
      errors++;
      $display("FAIL timeout_fire: got no chk_err expected one within %0d clks", TIMEOUT + 200);
    end else if (last_chk - last_bv != int'(TIMEOUT) || busy_at_chk !== 1'b0) begin
      errors++;
      $display("FAIL timeout_delay: got %0d busy=%b expected %0d busy=0", last_chk - last_bv, busy_at_chk, TIMEOUT);
    end
    wait_clks(20);
  endtask

  task automatic test_reset_mid_packet;
    int pv0;
    logic [PKT_W-1:0] p = seq_payload(8'h90);
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < 11; i++) send_byte(p[PKT_W-1-8*i -: 8], 1'b1);
    rxd = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 3; i++) begin
      rxd = p[PKT_W-1-8*11 + i];
      wait_clks(CPB);
    end
    rxd = 1'b1;
    rst_n = 1'b0;
    wait_clks(1);
    checks++;
    if (pkt_data !== '0 || {pkt_valid, frame_err, chk_err, rx_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset: got data=%0h flags=%b expected 0", pkt_data, {pkt_valid, frame_err, chk_err, rx_busy});
    end
    rst_n = 1'b1;
    last_good = '0;
    wait_clks(30);
    pv0 = n_pv;
    send_good(seq_payload(8'hB0));
    checks++;
    if (n_pv - pv0 != 1) begin
      errors++;
      $display("FAIL mid_reset_recover: got pv=%0d expected 1", n_pv - pv0);
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_checksum();
    test_sync_hunt();
    test_framing_error();
    test_glitch();
    test_timeout();
    test_reset_mid_packet();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
